// File: rtl/mem_tg2_sched_pkg.sv
// mem_tg2_sched_pkg: shared state codes, start-write defaults and channel search for the TG2 sequencer
package mem_tg2_sched_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECT    = 3'd1;
  localparam logic [2:0] ST_WR_START  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [9:0]  START_OFS_DEF = 10'h00F;
  localparam logic [31:0] START_VAL_DEF = 32'h1;
  localparam logic [4:0]  NONE_IDX      = 5'h10;
  typedef enum logic [1:0] {RES_NONE, RES_PASS, RES_FAIL, RES_TMO} res_code_e;
  // lowest enabled index >= ptr, or NONE_IDX (bit 4 set) when nothing is left
  function automatic logic [4:0] find_next(input logic [15:0] en, input logic [4:0] ptr);
    find_next = NONE_IDX;
    for (int i = 15; i >= 0; i--)
      if (en[i] && 5'(i) >= ptr) find_next = 5'(i);
  endfunction
endpackage

// File: rtl/mem_tg2_sched_wdog.sv
// mem_tg2_sched_wdog: per-channel watchdog, saturating counter with limit-based expiry
module mem_tg2_sched_wdog #(
  parameter int WDOG_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);
  logic [WDOG_W-1:0] cnt;
  // count cycles while enabled, holding at all-ones
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : (en && !(&cnt)) ? cnt + 1'b1 : cnt;
  assign expire = (limit != '0) && (cnt == limit - 1'b1);
endmodule

// File: rtl/mem_tg2_sched.sv
// mem_tg2_sched: runs TG2 channels one at a time via a shared AVMM config master
module mem_tg2_sched
  import mem_tg2_sched_pkg::*;
#(
  parameter int NUM_TG = 4,
  parameter int CFG_ADDR_W = 10,
  parameter int CFG_DATA_W = 32,
  parameter logic [CFG_ADDR_W-1:0] START_OFS = START_OFS_DEF,
  parameter logic [CFG_DATA_W-1:0] START_VAL = START_VAL_DEF,
  parameter int WDOG_W = 32,
  localparam int SEL_W = (NUM_TG > 1) ? $clog2(NUM_TG) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seq_start,
  input  logic                  seq_abort,
  input  logic [NUM_TG-1:0]     ch_enable,
  input  logic [WDOG_W-1:0]     wdog_limit,
  input  logic [NUM_TG-1:0]     tg_pass,
  input  logic [NUM_TG-1:0]     tg_fail,
  input  logic [NUM_TG-1:0]     tg_timeout,
  output logic [SEL_W-1:0]      cfg_sel,
  output logic                  cfg_write,
  output logic [CFG_ADDR_W-1:0] cfg_address,
  output logic [CFG_DATA_W-1:0] cfg_writedata,
  input  logic                  cfg_waitrequest,
  output logic [NUM_TG-1:0]     mem_tg_active,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [NUM_TG-1:0]     res_pass,
  output logic [NUM_TG-1:0]     res_fail,
  output logic [NUM_TG-1:0]     res_tmo,
  output logic                  res_aborted
);
  logic [2:0]        state;
  logic [NUM_TG-1:0] en_q;
  logic [4:0]        ptr;
  logic [4:0]        nxt;
  logic              abort_pend;
  logic              wd_expire;
  res_code_e         code;
  assign nxt = find_next(16'(en_q), ptr);
  mem_tg2_sched_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != ST_WAIT_DONE),
    .en     (state == ST_WAIT_DONE),
    .limit  (wdog_limit),
    .expire (wd_expire)
  );
  // status priority for the active channel: fail, TG2 timeout, pass, watchdog
  always_comb
    code = tg_fail[cfg_sel]    ? RES_FAIL :
           tg_timeout[cfg_sel] ? RES_TMO  :
           tg_pass[cfg_sel]    ? RES_PASS :
           wd_expire           ? RES_TMO  : RES_NONE;
  // sequencer FSM; every output is a register updated here
  always_ff @(posedge clk)
    if (reset) begin
      state         <= ST_IDLE;
      en_q          <= '0;
      ptr           <= '0;
      abort_pend    <= 1'b0;
      cfg_sel       <= '0;
      cfg_write     <= 1'b0;
      cfg_address   <= '0;
      cfg_writedata <= '0;
      mem_tg_active <= '0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      res_pass      <= '0;
      res_fail      <= '0;
      res_tmo       <= '0;
      res_aborted   <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (seq_start) begin
            en_q        <= ch_enable;
            ptr         <= '0;
            abort_pend  <= 1'b0;
            res_pass    <= '0;
            res_fail    <= '0;
            res_tmo     <= '0;
            res_aborted <= 1'b0;
            seq_busy    <= 1'b1;
            state       <= ST_SELECT;
          end
        ST_SELECT:
          if (seq_abort || nxt[4]) begin
            res_aborted <= seq_abort;
            seq_done    <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cfg_sel       <= SEL_W'(nxt);
            mem_tg_active <= NUM_TG'(1) << nxt;
            cfg_write     <= 1'b1;
            cfg_address   <= START_OFS;
            cfg_writedata <= START_VAL;
            state         <= ST_WR_START;
          end
        ST_WR_START: begin
          if (seq_abort) abort_pend <= 1'b1;
          if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            if (abort_pend || seq_abort) begin
              res_aborted   <= 1'b1;
              mem_tg_active <= '0;
              seq_done      <= 1'b1;
              state         <= ST_DONE;
            end else
              state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (code == RES_FAIL) res_fail[cfg_sel] <= 1'b1;
          if (code == RES_TMO)  res_tmo[cfg_sel]  <= 1'b1;
          if (code == RES_PASS) res_pass[cfg_sel] <= 1'b1;
          if (seq_abort) begin
            res_aborted   <= 1'b1;
            mem_tg_active <= '0;
            seq_done      <= 1'b1;
            state         <= ST_DONE;
          end else if (code != RES_NONE) begin
            ptr           <= 5'(cfg_sel) + 5'd1;
            mem_tg_active <= '0;
            state         <= ST_SELECT;
          end
        end
        ST_DONE: begin
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_tg2_sched.sv
// tb_mem_tg2_sched: directed checks of the TG2 channel sequencer
module tb_mem_tg2_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic        cfg_waitrequest = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [3:0]  tg_pass = '0;
  logic [3:0]  tg_fail = '0;
  logic [3:0]  tg_timeout = '0;
  logic [31:0] wdog_limit = '0;
  logic [1:0]  cfg_sel;
  logic        cfg_write;
  logic [9:0]  cfg_address;
  logic [31:0] cfg_writedata;
  logic [3:0]  mem_tg_active, res_pass, res_fail, res_tmo;
  logic        seq_busy, seq_done, res_aborted;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int w0, d0;

  mem_tg2_sched dut (
    .clk(clk), .reset(reset), .seq_start(seq_start), .seq_abort(seq_abort),
    .ch_enable(ch_enable), .wdog_limit(wdog_limit), .tg_pass(tg_pass),
    .tg_fail(tg_fail), .tg_timeout(tg_timeout), .cfg_sel(cfg_sel),
    .cfg_write(cfg_write), .cfg_address(cfg_address), .cfg_writedata(cfg_writedata),
    .cfg_waitrequest(cfg_waitrequest), .mem_tg_active(mem_tg_active),
    .seq_busy(seq_busy), .seq_done(seq_done), .res_pass(res_pass),
    .res_fail(res_fail), .res_tmo(res_tmo), .res_aborted(res_aborted)
  );

  always #5 clk = ~clk;

  // accepted writes and done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (cfg_write && !cfg_waitrequest) wr_cnt++;
    if (seq_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [3:0] en);
    ch_enable = en;
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!seq_done && k < 300) begin
      tick;
      k++;
    end
    chk(tag, 64'(seq_done), 64'd1);
    tick;
  endtask

  function automatic logic [63:0] outs();
    return {cfg_sel, cfg_write, cfg_address, cfg_writedata, mem_tg_active, seq_busy,
            seq_done, res_pass, res_fail, res_tmo, res_aborted};
  endfunction

  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("reset_outputs", outs(), 64'd0);

    // two passing channels, no waitrequest
    w0 = wr_cnt;
    d0 = done_cnt;
    start(4'b0101);
    chk("t1_busy_select", 64'(seq_busy), 64'd1);
    tick;
    chk("t1_wr0", {cfg_write, cfg_sel, mem_tg_active, cfg_address, cfg_writedata},
        {1'b1, 2'd0, 4'b0001, 10'h00F, 32'h1});
    tick;
    chk("t1_wait0", {cfg_write, mem_tg_active}, {1'b0, 4'b0001});
    repeat (19) tick;
    tg_pass = 4'b0001;
    tick;
    tg_pass = 4'b0000;
    chk("t1_pass0", {res_pass, mem_tg_active}, {4'b0001, 4'b0000});
    tick;
    chk("t1_wr2", {cfg_write, cfg_sel, mem_tg_active}, {1'b1, 2'd2, 4'b0100});
    tick;
    tg_pass = 4'b0100;
    tick;
    tg_pass = 4'b0000;
    chk("t1_pass2", 64'(res_pass), 64'(4'b0101));
    tick;
    chk("t1_done", 64'(seq_done), 64'd1);
    tick;
    chk("t1_idle", {seq_busy, seq_done, res_fail, res_tmo}, 10'd0);
    chk("t1_writes", 64'(wr_cnt - w0), 64'd2);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

    // waitrequest held 5 cycles, then TG2 timeout status
    cfg_waitrequest = 1'b1;
    w0 = wr_cnt;
    start(4'b0001);
    tick;
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold", {cfg_write, cfg_address, cfg_writedata}, {1'b1, 10'h00F, 32'h1});
      if (i == 5) cfg_waitrequest = 1'b0;
      tick;
    end
    chk("t2_wait_entry", {cfg_write, mem_tg_active}, {1'b0, 4'b0001});
    chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
    tg_timeout = 4'b0001;
    tick;
    tg_timeout = 4'b0000;
    chk("t2_tmo", {res_pass, res_fail, res_tmo}, {4'b0000, 4'b0000, 4'b0001});
    wait_done("t2_done");

    // watchdog expiry on channel 1
    wdog_limit = 32'd100;
    start(4'b0010);
    tick;
    chk("t3_wr1", {cfg_write, cfg_sel}, {1'b1, 2'd1});
    tick;
    repeat (99) tick;
    chk("t3_tmo_early", 64'(res_tmo), 64'd0);
    tick;
    chk("t3_tmo", {res_pass, res_fail, res_tmo}, {4'b0000, 4'b0000, 4'b0010});
    begin
      int k = 0;
      while (!seq_done && k < 2) begin
        tick;
        k++;
      end
    end
    chk("t3_done", 64'(seq_done), 64'd1);
    tick;
    wdog_limit = 32'd0;

    // fail beats pass in the same cycle
    start(4'b0001);
    tick;
    tick;
    tg_pass = 4'b0001;
    tg_fail = 4'b0001;
    tick;
    tg_pass = 4'b0000;
    tg_fail = 4'b0000;
    chk("t4_fail_prio", {res_pass, res_fail, res_tmo}, {4'b0000, 4'b0001, 4'b0000});
    wait_done("t4_done");

    // abort during a stalled write
    cfg_waitrequest = 1'b1;
    w0 = wr_cnt;
    start(4'b0011);
    tick;
    seq_abort = 1'b1;
    tick;
    seq_abort = 1'b0;
    chk("t5_no_truncate_a", 64'(cfg_write), 64'd1);
    tick;
    chk("t5_no_truncate_b", 64'(cfg_write), 64'd1);
    tick;
    cfg_waitrequest = 1'b0;
    tick;
    chk("t5_done", {seq_done, res_aborted, cfg_write, mem_tg_active}, {1'b1, 1'b1, 1'b0, 4'b0000});
    chk("t5_one_write", 64'(wr_cnt - w0), 64'd1);
    repeat (5) tick;
    chk("t5_no_more", {32'(wr_cnt - w0), 31'd0, seq_busy}, {32'd1, 32'd0});

    // nothing enabled
    w0 = wr_cnt;
    start(4'b0000);
    chk("t6_select", {seq_done, seq_busy}, 2'b01);
    tick;
    chk("t6_done", {seq_done, cfg_write, res_pass, res_fail, res_tmo, res_aborted}, {1'b1, 14'd0});
    tick;
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);

    // reset while waiting for status
    start(4'b0001);
    tick;
    tick;
    chk("t7_in_wait", {mem_tg_active, cfg_address}, {4'b0001, 10'h00F});
    reset = 1'b1;
    tick;
    chk("t7_reset_outputs", outs(), 64'd0);
    reset = 1'b0;
    tick;
    chk("t7_idle", {seq_busy, cfg_write, mem_tg_active}, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
